// File: rtl/mux2_arb_pkg.sv
// Shared definitions for the two-requester arbitrated mux: state encoding,
// requester IDs, the default hold limit and the arbitration helper.
package mux2_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GNT_A = 2'd1,
    GNT_B = 2'd2
  } state_e;

  // Requester IDs double as bit positions in req/done/gnt and as the
  // encoding of the last-served register.
  localparam logic ID_A = 1'b0;
  localparam logic ID_B = 1'b1;

  localparam int MAX_HOLD_DEF = 15;

  // Arbitration decision from the current requests and last-served ID.
  // A lone requester wins outright; on a tie the requester that was not
  // served last wins.
  function automatic state_e pick_next(input logic [1:0] req_v, input logic last_v);
    state_e nxt;
    case (req_v)
      2'b01:   nxt = GNT_A;
      2'b10:   nxt = GNT_B;
      2'b11:   nxt = (last_v == ID_B) ? GNT_A : GNT_B;
      default: nxt = IDLE;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/mux2g.sv
// Single-bit 2:1 multiplexer: y = sel ? d1 : d0.
module mux2g (
  input  logic d0,
  input  logic d1,
  input  logic sel,
  output logic y
);

  assign y = sel ? d1 : d0;

endmodule

// File: rtl/mux2_arb.sv
// Two-requester arbiter driving a shared W-bit 2:1 mux. Grants are
// round-robin on ties, bounded by MAX_HOLD when the other side waits,
// and hand over directly between requesters without an idle cycle.
module mux2_arb
  import mux2_arb_pkg::*;
#(
  parameter int W        = 8,
  parameter int MAX_HOLD = MAX_HOLD_DEF   // legal range 2..255
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [1:0]   req,
  input  logic [1:0]   done,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [1:0]   gnt,
  output logic         s,
  output logic [W-1:0] z,
  output logic         z_vld,
  output logic [7:0]   hold_cnt
);

  // Last hold_cnt value of a grant: preemption point with a contender,
  // saturation point without one.
  localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

  state_e     state_q, state_d;
  logic       last_q, last_d;
  logic [7:0] hold_q, hold_d;
  logic [1:0] gnt_q, gnt_d;
  logic       s_q, s_d;
  logic       z_vld_q, z_vld_d;

  // Next state, last-served and hold counter. A grant that ends (done,
  // dropped req or preemption) is re-arbitrated in the same edge with the
  // releaser recorded as last-served, so a lone releaser is simply re-granted.
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    hold_d  = hold_q;
    case (state_q)
      IDLE: begin
        state_d = pick_next(req, last_q);
        hold_d  = 8'd0;
      end
      GNT_A: begin
        if (done[ID_A] || !req[ID_A] || (hold_q == HOLD_LAST && req[ID_B])) begin
          state_d = pick_next(req, ID_A);
          last_d  = ID_A;
          hold_d  = 8'd0;
        end else if (hold_q != HOLD_LAST) begin
          hold_d = hold_q + 8'd1;
        end
      end
      GNT_B: begin
        if (done[ID_B] || !req[ID_B] || (hold_q == HOLD_LAST && req[ID_A])) begin
          state_d = pick_next(req, ID_B);
          last_d  = ID_B;
          hold_d  = 8'd0;
        end else if (hold_q != HOLD_LAST) begin
          hold_d = hold_q + 8'd1;
        end
      end
      default: begin
        state_d = IDLE;
        hold_d  = 8'd0;
      end
    endcase
  end

  // Registered outputs decoded from the next state; select keeps its last
  // value while idle so the shared output does not toggle.
  always_comb begin
    gnt_d   = 2'b00;
    s_d     = s_q;
    z_vld_d = 1'b0;
    case (state_d)
      GNT_A: begin
        gnt_d   = 2'b01;
        s_d     = 1'b0;
        z_vld_d = 1'b1;
      end
      GNT_B: begin
        gnt_d   = 2'b10;
        s_d     = 1'b1;
        z_vld_d = 1'b1;
      end
      default: begin
        gnt_d   = 2'b00;
        z_vld_d = 1'b0;
      end
    endcase
  end

  // State and output registers; reset leaves B as last-served so A wins
  // the first tie.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      last_q  <= ID_B;
      hold_q  <= 8'd0;
      gnt_q   <= 2'b00;
      s_q     <= 1'b0;
      z_vld_q <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      hold_q  <= hold_d;
      gnt_q   <= gnt_d;
      s_q     <= s_d;
      z_vld_q <= z_vld_d;
    end
  end

  assign gnt      = gnt_q;
  assign s        = s_q;
  assign z_vld    = z_vld_q;
  assign hold_cnt = hold_q;

  // Shared data path: one bit-mux per data bit, all steered by s.
  for (genvar gi = 0; gi < W; gi++) begin : g_bit
    mux2g u_mux (
      .d0  (a[gi]),
      .d1  (b[gi]),
      .sel (s_q),
      .y   (z[gi])
    );
  end

endmodule

// File: tb/tb_mux2_arb.sv
// Directed bench for mux2_arb with MAX_HOLD=4: reset, round-robin,
// preemption, saturation/re-grant, spurious done, async reset, data path.
module tb_mux2_arb;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [1:0] req = 2'b00;
  logic [1:0] done = 2'b00;
  logic [7:0] a = 8'h00;
  logic [7:0] b = 8'h00;
  logic [1:0] gnt;
  logic       s;
  logic [7:0] z;
  logic       z_vld;
  logic [7:0] hold_cnt;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  mux2_arb #(.W(8), .MAX_HOLD(4)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (req),
    .done     (done),
    .a        (a),
    .b        (b),
    .gnt      (gnt),
    .s        (s),
    .z        (z),
    .z_vld    (z_vld),
    .hold_cnt (hold_cnt)
  );

  always #5 clk = ~clk;

  // One clock edge; outputs are sampled 1 ns after it.
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    $display("cyc=%0d rst_n=%b req=%b done=%b gnt=%b s=%b z=%h z_vld=%b hold=%0d",
             cyc, rst_n, req, done, gnt, s, z, z_vld, hold_cnt);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req   = 2'b00;
    done  = 2'b00;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    a = 8'hA5;
    b = 8'h3C;
    req = 2'b11;
    #2 rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (gnt !== 2'b00) begin errors++; $display("FAIL reset_gnt: got %b expected 00", gnt); end
      checks++;
      if (z_vld !== 1'b0 || s !== 1'b0 || hold_cnt !== 8'd0) begin
        errors++; $display("FAIL reset_outs: got z_vld=%b s=%b hold=%0d expected 0/0/0", z_vld, s, hold_cnt);
      end
    end
    rst_n = 1'b1;
    tick();
    checks++;
    if (gnt !== 2'b01) begin errors++; $display("FAIL reset_first_gnt: got %b expected 01", gnt); end
    checks++;
    if (z !== 8'hA5 || z_vld !== 1'b1) begin
      errors++; $display("FAIL reset_first_z: got z=%h z_vld=%b expected a5/1", z, z_vld);
    end
  endtask

  task automatic test_round_robin();
    logic [1:0] exp_gnt;
    do_reset();
    req = 2'b11;
    tick();
    exp_gnt = 2'b01;
    for (int g = 0; g < 4; g++) begin
      for (int j = 0; j < 3; j++) begin
        checks++;
        if (gnt !== exp_gnt) begin errors++; $display("FAIL rr_gnt: grant %0d cycle %0d got %b expected %b", g, j, gnt, exp_gnt); end
        checks++;
        if (hold_cnt !== 8'(j)) begin errors++; $display("FAIL rr_hold: grant %0d got %0d expected %0d", g, hold_cnt, j); end
        if (j == 2) done = exp_gnt;
        tick();
        done = 2'b00;
      end
      exp_gnt = (exp_gnt == 2'b01) ? 2'b10 : 2'b01;
    end
  endtask

  task automatic test_preempt();
    do_reset();
    req = 2'b01;
    tick();
    req = 2'b11;
    for (int j = 0; j < 4; j++) begin
      checks++;
      if (gnt !== 2'b01 || hold_cnt !== 8'(j)) begin
        errors++; $display("FAIL preempt_hold: got gnt=%b hold=%0d expected 01/%0d", gnt, hold_cnt, j);
      end
      tick();
    end
    checks++;
    if (gnt !== 2'b10 || hold_cnt !== 8'd0) begin
      errors++; $display("FAIL preempt_switch: got gnt=%b hold=%0d expected 10/0", gnt, hold_cnt);
    end
    checks++;
    if (s !== 1'b1 || z !== 8'h3C) begin errors++; $display("FAIL preempt_data: got s=%b z=%h expected 1/3c", s, z); end
    req = 2'b00;
    tick();
  endtask

  task automatic test_saturation();
    do_reset();
    req = 2'b01;
    for (int i = 0; i < 20; i++) begin
      tick();
      checks++;
      if (gnt !== 2'b01 || hold_cnt !== ((i < 3) ? 8'(i) : 8'd3)) begin
        errors++; $display("FAIL sat_hold: cycle %0d got gnt=%b hold=%0d expected 01/%0d", i, gnt, hold_cnt, (i < 3) ? i : 3);
      end
    end
    done = 2'b01;
    tick();
    done = 2'b00;
    checks++;
    if (gnt !== 2'b01 || hold_cnt !== 8'd0) begin
      errors++; $display("FAIL regrant: got gnt=%b hold=%0d expected 01/0", gnt, hold_cnt);
    end
    tick();
    checks++;
    if (hold_cnt !== 8'd1) begin errors++; $display("FAIL regrant_count: got %0d expected 1", hold_cnt); end
  endtask

  task automatic test_spurious_done();
    do_reset();
    done = 2'b11;
    tick();
    checks++;
    if (gnt !== 2'b00) begin errors++; $display("FAIL idle_done: got %b expected 00", gnt); end
    done = 2'b00;
    req = 2'b01;
    tick();
    done = 2'b10;
    tick();
    done = 2'b00;
    checks++;
    if (gnt !== 2'b01 || hold_cnt !== 8'd1) begin
      errors++; $display("FAIL spurious_done: got gnt=%b hold=%0d expected 01/1", gnt, hold_cnt);
    end
    // Asynchronous reset mid-grant, checked before the next clock edge.
    rst_n = 1'b0;
    #2;
    checks++;
    if (gnt !== 2'b00 || z_vld !== 1'b0 || hold_cnt !== 8'd0) begin
      errors++; $display("FAIL async_reset: got gnt=%b z_vld=%b hold=%0d expected 00/0/0", gnt, z_vld, hold_cnt);
    end
    rst_n = 1'b1;
    tick();
    checks++;
    if (gnt !== 2'b01 || hold_cnt !== 8'd0) begin
      errors++; $display("FAIL reset_restart: got gnt=%b hold=%0d expected 01/0", gnt, hold_cnt);
    end
    req = 2'b00;
    tick();
    checks++;
    if (gnt !== 2'b00 || z_vld !== 1'b0) begin
      errors++; $display("FAIL req_drop: got gnt=%b z_vld=%b expected 00/0", gnt, z_vld);
    end
  endtask

  task automatic test_datapath();
    do_reset();
    a = 8'hA5;
    b = 8'h3C;
    req = 2'b11;
    tick();
    checks++;
    if (gnt !== 2'b01 || s !== 1'b0 || z !== 8'hA5) begin
      errors++; $display("FAIL dp_a: got gnt=%b s=%b z=%h expected 01/0/a5", gnt, s, z);
    end
    done = 2'b01;
    tick();
    checks++;
    if (gnt !== 2'b10 || s !== 1'b1 || z !== 8'h3C) begin
      errors++; $display("FAIL dp_b: got gnt=%b s=%b z=%h expected 10/1/3c", gnt, s, z);
    end
    done = 2'b10;
    tick();
    checks++;
    if (gnt !== 2'b01 || s !== 1'b0 || z !== 8'hA5) begin
      errors++; $display("FAIL dp_a2: got gnt=%b s=%b z=%h expected 01/0/a5", gnt, s, z);
    end
    done = 2'b01;
    tick();
    done = 2'b00;
    req = 2'b00;
    tick();
    checks++;
    if (gnt !== 2'b00 || s !== 1'b1 || z !== 8'h3C || z_vld !== 1'b0) begin
      errors++; $display("FAIL dp_idle_hold: got gnt=%b s=%b z=%h z_vld=%b expected 00/1/3c/0", gnt, s, z, z_vld);
    end
    a = 8'h11;
    tick();
    checks++;
    if (z !== 8'h3C) begin errors++; $display("FAIL dp_idle_stable: got z=%h expected 3c", z); end
    b = 8'h77;
    #1;
    checks++;
    if (z !== 8'h77) begin errors++; $display("FAIL dp_comb: got z=%h expected 77", z); end
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_preempt();
    test_saturation();
    test_spurious_done();
    test_datapath();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
